tmds_deserializer: RTL and testbench
====================================

TMDS_DESERIALIZER -- requirements
Module: tmds_deserializer

Interface
REQ-001 Parameter LOCK_COUNT, default 8, SHALL be the number of consecutive control-token words needed to declare lock (range 2..255).
REQ-002 Parameter MISS_LIMIT, default 64, SHALL be the number of consecutive non-token words in SEARCH before a one-bit slip (range 2..4095).
REQ-003 Parameter LOSS_LIMIT, default 4096, SHALL be the number of consecutive non-token words in LOCKED before lock is dropped (range 2..8191).
REQ-004 clk_pixel_x5  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  SHALL be asynchronous and active-high.
REQ-006 serial_pair  input  2  SHALL carry two DDR-captured line bits per cycle; bit [0] SHALL be earlier in time than bit [1].
REQ-007 tmds_word  output  10  SHALL be the aligned 10-bit TMDS symbol; bit 0 SHALL be the first bit received.
REQ-008 word_valid  output  1  SHALL be a one-cycle strobe qualifying tmds_word.
REQ-009 locked  output  1  SHALL be high only in state LOCKED.
REQ-010 bit_offset  output  4  SHALL be the current alignment offset, 0..9.

Function
REQ-011 Shift: hist[19:0] SHALL update every cycle as hist <= {serial_pair[1], serial_pair[0], hist[19:2]}.
REQ-012 Phase: a counter SHALL cycle 0,1,2,3,4,0,...; a word boundary SHALL occur on the edge where phase == 4.
REQ-013 Extraction: at each boundary, tmds_word SHALL be registered from hist[19-bit_offset : 10-bit_offset], using pre-edge hist.
REQ-014 Strobe: word_valid SHALL be high for exactly the cycle following each boundary, once every 5 cycles, in every state.
REQ-015 Tokens: the control tokens SHALL be 10'b1101010100, 10'b0010101011, 10'b0101010100 and 10'b1010101011; a word is a token if it equals any of these.
REQ-016 The FSM SHALL have three states, SEARCH, VERIFY and LOCKED, and SHALL evaluate only at boundaries, using the word being extracted.
REQ-017 SEARCH, token word: the FSM SHALL set match_cnt=1, clear miss_cnt and go to VERIFY.
REQ-018 SEARCH, non-token word: miss_cnt SHALL increment; when it reaches MISS_LIMIT, bit_offset SHALL advance by 1 (9 wraps to 0) and miss_cnt SHALL clear.
REQ-019 VERIFY, token word: match_cnt SHALL increment; when it reaches LOCK_COUNT, the FSM SHALL go to LOCKED, clear miss_cnt and register locked=1.
REQ-020 VERIFY, non-token word: the FSM SHALL return to SEARCH with match_cnt and miss_cnt cleared; no slip SHALL occur.
REQ-021 LOCKED, token word: miss_cnt SHALL clear.
REQ-022 LOCKED, non-token word: miss_cnt SHALL increment; at LOSS_LIMIT, the FSM SHALL go to SEARCH, advance bit_offset by 1, clear counters and drop locked on the same edge.
REQ-023 Offset changes SHALL take effect from the next boundary; the phase counter SHALL never be altered by a slip.
REQ-024 Counters SHALL saturate-free wrap; the counter widths SHALL hold the maximum parameter values without overflow.

Reset
REQ-025 On reset assertion, regardless of clock, the block SHALL force hist=0, phase=0, bit_offset=0, state=SEARCH, match_cnt=0, miss_cnt=0, tmds_word=0, word_valid=0 and locked=0.
REQ-026 After reset deasserts, the first boundary SHALL be the 5th rising edge; a reset mid-word or while LOCKED SHALL discard all partial data.

Verification
REQ-027 Aligned stream: repeat 1101010100 LSB-first, offset 0 -> locked=1 after exactly 8 boundaries; tmds_word=10'b1101010100 and bit_offset=0.
REQ-028 Misaligned: same stream delayed 3 bits, MISS_LIMIT=4 -> bit_offset steps 1,2,3, then lock at offset 3; tmds_word equals the token.
REQ-029 Wrap: stream delayed 9 bits, then once slip passes -> offset sequence 1..9 reached without error; a slip at offset 9 yields 0.
REQ-030 VERIFY abort: 5 tokens then 1 data word 0x1F0 -> state returns to SEARCH with bit_offset unchanged and locked still 0.
REQ-031 Loss: locked, then LOSS_LIMIT=16 non-token words -> locked falls on the 16th boundary and bit_offset increments by 1; 15 non-tokens followed by a token keeps locked=1.
REQ-032 Async reset: assert reset for 1 ns mid-cycle while LOCKED -> all outputs are 0 immediately; word_valid first pulses 5 cycles after release.

Source files
------------

// File: rtl/tmds_deserializer_if.sv
// TMDS deserializer data interface: the serial input pair and the aligned
// word, strobe and lock status coming back from the deserializer.
interface tmds_deserializer_if;
  logic [1:0] serial_pair;  // bit [0] is earlier on the line than bit [1]
  logic [9:0] tmds_word;    // bit 0 is the first bit received
  logic       word_valid;
  logic       locked;
  logic [3:0] bit_offset;

  // Stream source / status consumer.
  modport master (
    output serial_pair,
    input  tmds_word,
    input  word_valid,
    input  locked,
    input  bit_offset
  );

  // Deserializer side.
  modport slave (
    input  serial_pair,
    output tmds_word,
    output word_valid,
    output locked,
    output bit_offset
  );
endinterface

// File: rtl/tmds_deserializer.sv
// TMDS deserializer: collects two line bits per clk_pixel_x5 cycle into a
// 20-bit history, cuts a 10-bit symbol every fifth cycle at a selectable bit
// offset, and hunts for word alignment by watching for control tokens.
module tmds_deserializer #(
  parameter int unsigned LOCK_COUNT = 8,     // 2..255
  parameter int unsigned MISS_LIMIT = 64,    // 2..4095
  parameter int unsigned LOSS_LIMIT = 4096   // 2..8191
) (
  input  logic                 clk_pixel_x5,
  input  logic                 reset,
  tmds_deserializer_if.slave   bus
);

  // One miss counter serves both SEARCH and LOCKED, so it is sized for the
  // larger of the two limits.
  localparam int unsigned MAX_MISS = (MISS_LIMIT > LOSS_LIMIT) ? MISS_LIMIT : LOSS_LIMIT;
  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W  = $clog2(MAX_MISS + 1);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  logic [19:0]        r_hist;
  logic [2:0]         r_phase;
  logic [3:0]         r_offset;
  state_t             r_state;
  logic [MATCH_W-1:0] r_match_cnt;
  logic [MISS_W-1:0]  r_miss_cnt;
  logic [9:0]         r_word;
  logic               r_valid;
  logic               r_locked;

  logic               w_boundary;
  logic [4:0]         w_msb;
  logic [9:0]         w_word;
  logic               w_is_token;
  logic [3:0]         w_offset_slip;
  logic [MATCH_W-1:0] w_match_inc;
  logic [MISS_W-1:0]  w_miss_inc;
  state_t             w_next_state;
  logic [MATCH_W-1:0] w_next_match;
  logic [MISS_W-1:0]  w_next_miss;
  logic [3:0]         w_next_offset;

  assign w_boundary    = (r_phase == 3'd4);
  // Offset 0 takes the newest ten bits; larger offsets reach further back.
  assign w_msb         = 5'd19 - {1'b0, r_offset};
  assign w_word        = r_hist[w_msb -: 10];
  assign w_is_token    = (w_word == 10'b1101010100) || (w_word == 10'b0010101011) ||
                         (w_word == 10'b0101010100) || (w_word == 10'b1010101011);
  assign w_offset_slip = (r_offset == 4'd9) ? 4'd0 : r_offset + 4'd1;
  assign w_match_inc   = r_match_cnt + MATCH_W'(1);
  assign w_miss_inc    = r_miss_cnt + MISS_W'(1);

  // Shift history, run the 5-cycle phase and capture the word at each boundary.
  // NOTE: every register here, the 20-bit history included, is cleared by the
  // async reset so a reset mid-word leaves no stale bits to leak into a symbol.
  always_ff @(posedge clk_pixel_x5 or posedge reset) begin
    if (reset) begin
      r_hist  <= '0;
      r_phase <= '0;
      r_word  <= '0;
      r_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values; the word cut below must see the history before this shift.
      r_hist  <= {bus.serial_pair[1], bus.serial_pair[0], r_hist[19:2]};
      r_phase <= w_boundary ? 3'd0 : r_phase + 3'd1;
      r_valid <= w_boundary;
      if (w_boundary) begin
        r_word <= w_word;
      end
    end
  end

  // Alignment FSM state, counters, offset and registered lock flag.
  always_ff @(posedge clk_pixel_x5 or posedge reset) begin
    if (reset) begin
      r_state     <= SEARCH;
      r_match_cnt <= '0;
      r_miss_cnt  <= '0;
      r_offset    <= '0;
      r_locked    <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_match_cnt <= w_next_match;
      r_miss_cnt  <= w_next_miss;
      r_offset    <= w_next_offset;
      r_locked    <= (w_next_state == LOCKED);
    end
  end

  // Next-state logic, evaluated only on the word boundary.
  always_comb begin
    // NOTE: hold-current defaults first, so no path through the case leaves a
    // signal unassigned and no latch is inferred.
    w_next_state  = r_state;
    w_next_match  = r_match_cnt;
    w_next_miss   = r_miss_cnt;
    w_next_offset = r_offset;
    if (w_boundary) begin
      unique case (r_state)
        SEARCH: begin
          if (w_is_token) begin
            w_next_state = VERIFY;
            w_next_match = MATCH_W'(1);
            w_next_miss  = '0;
          end else if (w_miss_inc == MISS_W'(MISS_LIMIT)) begin
            w_next_miss   = '0;
            w_next_offset = w_offset_slip;
          end else begin
            w_next_miss = w_miss_inc;
          end
        end
        VERIFY: begin
          if (w_is_token) begin
            w_next_match = w_match_inc;
            if (w_match_inc == MATCH_W'(LOCK_COUNT)) begin
              w_next_state = LOCKED;
              w_next_miss  = '0;
            end
          end else begin
            // A broken run restarts the hunt at the same offset.
            w_next_state = SEARCH;
            w_next_match = '0;
            w_next_miss  = '0;
          end
        end
        LOCKED: begin
          if (w_is_token) begin
            w_next_miss = '0;
          end else if (w_miss_inc == MISS_W'(LOSS_LIMIT)) begin
            w_next_state  = SEARCH;
            w_next_offset = w_offset_slip;
            w_next_match  = '0;
            w_next_miss   = '0;
          end else begin
            w_next_miss = w_miss_inc;
          end
        end
        default: begin
          w_next_state = SEARCH;
          w_next_match = '0;
          w_next_miss  = '0;
        end
      endcase
    end
  end

  assign bus.tmds_word  = r_word;
  assign bus.word_valid = r_valid;
  assign bus.locked     = r_locked;
  assign bus.bit_offset = r_offset;

endmodule

// File: tb/tb_tmds_deserializer.sv
// Testbench for tmds_deserializer: table-driven alignment scenarios plus
// hand-written sequences for VERIFY abort, loss of lock, offset wrap and
// asynchronous reset.
module tb_tmds_deserializer;

  localparam logic [9:0] TOK_A = 10'b1101010100;
  localparam logic [9:0] TOK_B = 10'b0010101011;
  localparam logic [9:0] DATA  = 10'h1F0;

  logic clk = 1'b0;
  logic reset = 1'b0;

  tmds_deserializer_if bus ();

  tmds_deserializer #(
    .LOCK_COUNT (8),
    .MISS_LIMIT (4),
    .LOSS_LIMIT (16)
  ) dut (
    .clk_pixel_x5 (clk),
    .reset        (reset),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Stream description. Stream bit i belongs to word (i+2+skew)/10 at
  // position (i+2+skew)%10, so word w is the one cut at boundary w+1 when
  // bit_offset == skew. Words inside either window carry DATA instead.
  logic [9:0] tok;
  int skew;
  int a1_from, a1_to, a2_from, a2_to;
  int bitpos;
  int b;  // boundaries (word_valid pulses) seen since reset

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic s_bit(input int i);
    int q;
    int w;
    logic [9:0] wd;
    q  = i + 2 + skew;
    w  = q / 10;
    wd = tok;
    if ((w >= a1_from && w < a1_to) || (w >= a2_from && w < a2_to)) wd = DATA;
    return wd[q % 10];
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.serial_pair = 2'b00;
    @(negedge clk);
    reset = 1'b0;
    bitpos = 0;
    b = 0;
  endtask

  task automatic start(input logic [9:0] t, input int sk,
                       input int f1, input int t1, input int f2, input int t2);
    tok = t; skew = sk;
    a1_from = f1; a1_to = t1; a2_from = f2; a2_to = t2;
    do_reset();
  endtask

  // One clock: drive the next two line bits, then sample on the falling edge.
  task automatic tick();
    bus.serial_pair = {s_bit(bitpos + 1), s_bit(bitpos)};
    bitpos += 2;
    @(posedge clk);
    @(negedge clk);
    if (bus.word_valid) b++;
  endtask

  task automatic run_to(input int target);
    int budget;
    int cyc;
    budget = (target - b) * 5 + 20;
    cyc = 0;
    while (b < target && cyc < budget) begin
      tick();
      cyc++;
    end
    if (b < target) begin
      n_checks++;
      n_err++;
      $display("FAIL timeout waiting for boundary %0d: reached %0d", target, b);
    end
  endtask

  task automatic run_until_locked(output int at_b);
    int cyc;
    cyc = 0;
    while (!bus.locked && cyc < 400) begin
      tick();
      cyc++;
    end
    if (bus.locked) begin
      at_b = b;
    end else begin
      at_b = -1;
      n_checks++;
      n_err++;
      $display("FAIL timeout waiting for lock: got locked=0 expected 1");
    end
  endtask

  typedef struct {
    logic [9:0] tok;
    int         skew;
    int         lock_b;
    logic [3:0] off;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int lb;
    int walk_err;
    int exp_off;

    // MISS_LIMIT=4: each wrong offset costs 4 boundaries, then 8 tokens lock.
    vecs[0] = '{tok: TOK_A, skew: 0, lock_b: 8,  off: 4'd0};
    vecs[1] = '{tok: TOK_A, skew: 3, lock_b: 20, off: 4'd3};
    vecs[2] = '{tok: TOK_A, skew: 5, lock_b: 28, off: 4'd5};
    vecs[3] = '{tok: TOK_A, skew: 7, lock_b: 36, off: 4'd7};
    // First word carries two reset zeros where TOK_B has a 1: one miss.
    vecs[4] = '{tok: TOK_B, skew: 0, lock_b: 9,  off: 4'd0};

    bus.serial_pair = 2'b00;
    tok = TOK_A; skew = 0;
    a1_from = -1; a1_to = -1; a2_from = -1; a2_to = -1;
    bitpos = 0; b = 0;

    // Reset state
    #1 reset = 1'b1;
    #1;
    check("rst_tmds_word",  32'(bus.tmds_word),  32'h0);
    check("rst_word_valid", 32'(bus.word_valid), 32'h0);
    check("rst_locked",     32'(bus.locked),     32'h0);
    check("rst_bit_offset", 32'(bus.bit_offset), 32'h0);

    // Alignment table
    for (int i = 0; i < 5; i++) begin
      start(vecs[i].tok, vecs[i].skew, -1, -1, -1, -1);
      run_until_locked(lb);
      check($sformatf("vec%0d_lock_boundary", i), 32'(lb), 32'(vecs[i].lock_b));
      check($sformatf("vec%0d_bit_offset", i), 32'(bus.bit_offset), 32'(vecs[i].off));
      check($sformatf("vec%0d_tmds_word", i), 32'(bus.tmds_word), 32'(vecs[i].tok));
    end

    // VERIFY abort: 5 tokens, then DATA at boundary 6, then tokens again
    start(TOK_A, 0, 5, 6, -1, -1);
    run_to(6);
    check("abort_tmds_word",  32'(bus.tmds_word),  32'(DATA));
    check("abort_locked",     32'(bus.locked),     32'h0);
    check("abort_bit_offset", 32'(bus.bit_offset), 32'h0);
    run_until_locked(lb);
    check("abort_relock_boundary", 32'(lb), 32'd14);

    // Loss: 15 non-tokens (b9..b23) keep lock; 16 (b31..b46) drop it
    start(TOK_A, 0, 8, 23, 30, 46);
    run_to(23);
    check("loss15_locked", 32'(bus.locked), 32'h1);
    run_to(24);
    check("loss15_token_locked", 32'(bus.locked), 32'h1);
    run_to(45);
    check("loss16_pre_locked", 32'(bus.locked), 32'h1);
    run_to(46);
    check("loss16_locked",     32'(bus.locked),     32'h0);
    check("loss16_bit_offset", 32'(bus.bit_offset), 32'h1);

    // Wrap: walk offsets 0..9, lock at 9, then lose lock so 9 slips to 0
    start(TOK_A, 9, 44, 60, -1, -1);
    walk_err = 0;
    for (int t = 1; t <= 44; t++) begin
      run_to(t);
      exp_off = (t / 4 > 9) ? 9 : t / 4;
      if (bus.bit_offset !== 4'(exp_off)) walk_err++;
    end
    check("wrap_offset_walk_errors", 32'(walk_err), 32'h0);
    check("wrap_locked",     32'(bus.locked),     32'h1);
    check("wrap_bit_offset", 32'(bus.bit_offset), 32'd9);
    run_to(60);
    check("wrap_loss_locked",     32'(bus.locked),     32'h0);
    check("wrap_loss_bit_offset", 32'(bus.bit_offset), 32'h0);

    // Asynchronous reset while locked
    start(TOK_A, 0, -1, -1, -1, -1);
    run_until_locked(lb);
    tick();
    tick();
    bus.serial_pair = 2'b00;
    @(posedge clk);
    #2 reset = 1'b1;
    #0.5;
    check("arst_tmds_word",  32'(bus.tmds_word),  32'h0);
    check("arst_word_valid", 32'(bus.word_valid), 32'h0);
    check("arst_locked",     32'(bus.locked),     32'h0);
    check("arst_bit_offset", 32'(bus.bit_offset), 32'h0);
    #0.5 reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("arst_valid_edge%0d", k), 32'(bus.word_valid), (k == 5) ? 32'h1 : 32'h0);
    end
    // Held-zero input: any surviving pre-reset history would show up here.
    check("arst_first_word", 32'(bus.tmds_word), 32'h0);
    check("arst_first_locked", 32'(bus.locked), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
